// File: rtl/genius_player_input.sv
// Genius player input: button sync/debounce and sequence replay check.
// Optional per-press inactivity timeout enabled by GENIUS_TIMEOUT_EN.
module genius_player_input #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] round_len,
  input  logic       bt0,
  input  logic       bt1,
  input  logic       bt2,
  output logic [3:0] seq_addr,
  input  logic [1:0] seq_sym,
  output logic       busy,
  output logic       press_valid,
  output logic [1:0] last_sym,
  output logic [4:0] press_count,
  output logic       done,
  output logic       success,
  output logic       fail,
  output logic       timeout
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 ||
      TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("genius_player_input: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE, WAIT_PRESS, WAIT_RELEASE, PASS, FAIL
  } state_t;

  localparam logic [7:0] DB_MAX = 8'(DEBOUNCE_CYCLES - 1);

  state_t     state, state_n;
  logic [2:0] raw, s1, s2, db;
  logic [7:0] cnt [3];
  logic [1:0] sym;
  logic       one_hot;
  logic [4:0] rlen, rlen_n, pc_n;
  logic [3:0] idx_n;
  logic [1:0] ls_n;
  logic       busy_n, pv_n, done_n, succ_n, fail_n;

  assign raw = {bt2, bt1, bt0};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // db flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      db <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_MAX) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    sym     = 2'd0;
    one_hot = 1'b1;
    unique case (db)
      3'b001:  sym = 2'd0;
      3'b010:  sym = 2'd1;
      3'b100:  sym = 2'd2;
      default: one_hot = 1'b0;
    endcase
  end

`ifdef GENIUS_TIMEOUT_EN
  logic [31:0] tcnt;
  logic        tmo_q, tmo_n;
  logic        tmo_hit;

  assign timeout = tmo_q;
  assign tmo_hit = (tcnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_n;
      if (state != WAIT_PRESS) tcnt <= '0;
      else                     tcnt <= tcnt + 32'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      seq_addr    <= '0;
      rlen        <= '0;
      busy        <= 1'b0;
      press_valid <= 1'b0;
      last_sym    <= '0;
      press_count <= '0;
      done        <= 1'b0;
      success     <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_n;
      seq_addr    <= idx_n;
      rlen        <= rlen_n;
      busy        <= busy_n;
      press_valid <= pv_n;
      last_sym    <= ls_n;
      press_count <= pc_n;
      done        <= done_n;
      success     <= succ_n;
      fail        <= fail_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = seq_addr;
    rlen_n  = rlen;
    busy_n  = busy;
    pv_n    = 1'b0;
    ls_n    = last_sym;
    pc_n    = press_count;
    done_n  = 1'b0;
    succ_n  = success;
    fail_n  = fail;
`ifdef GENIUS_TIMEOUT_EN
    tmo_n   = tmo_q;
`endif
    // busy drops on the same edge that ends the done pulse
    if (done) busy_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !busy) begin
          busy_n  = 1'b1;
          idx_n   = '0;
          rlen_n  = round_len;
          pc_n    = '0;
          succ_n  = 1'b0;
          fail_n  = 1'b0;
`ifdef GENIUS_TIMEOUT_EN
          tmo_n   = 1'b0;
`endif
          state_n = (round_len == 5'd0) ? PASS : WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (one_hot) begin
          pv_n = 1'b1;
          ls_n = sym;
          if (sym == seq_sym) begin
            pc_n    = press_count + 5'd1;
            state_n = WAIT_RELEASE;
          end else begin
            state_n = FAIL;
          end
        end else if (db != 3'b000) begin
          state_n = FAIL;
        end
`ifdef GENIUS_TIMEOUT_EN
        else if (tmo_hit) begin
          tmo_n   = 1'b1;
          state_n = FAIL;
        end
`endif
      end
      WAIT_RELEASE: begin
        if (db == 3'b000) begin
          if (press_count == rlen) begin
            state_n = PASS;
          end else begin
            idx_n   = seq_addr + 4'd1;
            state_n = WAIT_PRESS;
          end
        end
      end
      PASS: begin
        succ_n  = 1'b1;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      FAIL: begin
        fail_n  = 1'b1;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_genius_player_input.sv
// Scoreboard bench for genius_player_input.
// Press and done events are checked against queued expectations.
module tb_genius_player_input;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] round_len = '0;
  logic       bt0 = 1'b0;
  logic       bt1 = 1'b0;
  logic       bt2 = 1'b0;
  logic [3:0] seq_addr;
  logic [1:0] seq_sym;
  logic       busy, press_valid, done;
  logic       success, fail, timeout;
  logic [1:0] last_sym;
  logic [4:0] press_count;

  logic [1:0] mem [16];
  int checks = 0;
  int errors = 0;
  int pv_seen = 0;
  int done_seen = 0;
  int pv0, d0;

  typedef struct {
    logic [1:0] sym;
    logic [4:0] cnt;
  } press_t;

  typedef struct {
    logic succ;
    logic fl;
    logic tmo;
  } done_t;

  press_t pq[$];
  done_t  dq[$];
  press_t pe;
  done_t  de;

  always #5 clock = ~clock;

  assign seq_sym = mem[seq_addr];

  genius_player_input #(
    .DEBOUNCE_CYCLES(2),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .start      (start),
    .round_len  (round_len),
    .bt0        (bt0),
    .bt1        (bt1),
    .bt2        (bt2),
    .seq_addr   (seq_addr),
    .seq_sym    (seq_sym),
    .busy       (busy),
    .press_valid(press_valid),
    .last_sym   (last_sym),
    .press_count(press_count),
    .done       (done),
    .success    (success),
    .fail       (fail),
    .timeout    (timeout)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (rst_n) begin
      if (press_valid) begin
        pv_seen++;
        if (pq.size() == 0) begin
          check("unexp_pv", 32'(press_valid), 0);
        end else begin
          pe = pq.pop_front();
          check("last_sym", 32'(last_sym), 32'(pe.sym));
          check("press_count", 32'(press_count), 32'(pe.cnt));
        end
      end
      if (done) begin
        done_seen++;
        if (dq.size() == 0) begin
          check("unexp_done", 32'(done), 0);
        end else begin
          de = dq.pop_front();
          check("success", 32'(success), 32'(de.succ));
          check("fail", 32'(fail), 32'(de.fl));
          check("timeout", 32'(timeout), 32'(de.tmo));
          check("busy_at_done", 32'(busy), 1);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic go(input int len);
    round_len = 5'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic press(input int b);
    {bt2, bt1, bt0} = 3'(1 << b);
    tick(6);
    {bt2, bt1, bt0} = 3'b000;
    tick(6);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      tick();
    end
    check(tag, 32'(busy), 0);
  endtask

  function automatic logic [31:0] outs();
    return 32'({seq_addr, busy, press_valid, last_sym,
                press_count, done, success, fail, timeout});
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;
    tick(2);
    check("reset_outs", outs(), 0);
    rst_n = 1'b1;
    tick(2);

    // reset while holding a matched press
    mem[0] = 2'd0; mem[1] = 2'd0; mem[2] = 2'd1;
    go(3);
    check("start_busy", 32'(busy), 1);
    pq.push_back('{sym: 2'd0, cnt: 5'd1});
    bt0 = 1'b1;
    tick(6);
    check("hold_count", 32'(press_count), 1);
    #2 rst_n = 1'b0;
    #1 check("midrst_outs", outs(), 0);
    bt0 = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // correct round 0,0,1
    pv0 = pv_seen;
    go(3);
    pq.push_back('{sym: 2'd0, cnt: 5'd1});
    pq.push_back('{sym: 2'd0, cnt: 5'd2});
    pq.push_back('{sym: 2'd1, cnt: 5'd3});
    dq.push_back('{succ: 1'b1, fl: 1'b0, tmo: 1'b0});
    press(0);
    check("addr1", 32'(seq_addr), 1);
    press(0);
    check("addr2", 32'(seq_addr), 2);
    press(1);
    wait_idle("idle_ok");
    check("ok_pv", 32'(pv_seen - pv0), 3);
    check("ok_count", 32'(press_count), 3);
    check("ok_succ", 32'(success), 1);
    tick(2);

    // wrong second press
    mem[0] = 2'd0; mem[1] = 2'd1;
    pv0 = pv_seen;
    go(2);
    check("clr_succ", 32'(success), 0);
    pq.push_back('{sym: 2'd0, cnt: 5'd1});
    pq.push_back('{sym: 2'd2, cnt: 5'd1});
    dq.push_back('{succ: 1'b0, fl: 1'b1, tmo: 1'b0});
    press(0);
    press(2);
    wait_idle("idle_bad");
    check("bad_pv", 32'(pv_seen - pv0), 2);
    check("bad_sym", 32'(last_sym), 2);
    check("bad_count", 32'(press_count), 1);
    check("bad_fail", 32'(fail), 1);
    tick(2);

    // glitch then simultaneous press
    mem[0] = 2'd1;
    pv0 = pv_seen;
    go(1);
    bt1 = 1'b1;
    tick();
    bt1 = 1'b0;
    tick(10);
    check("glitch_pv", 32'(pv_seen - pv0), 0);
    check("glitch_busy", 32'(busy), 1);
    dq.push_back('{succ: 1'b0, fl: 1'b1, tmo: 1'b0});
    {bt1, bt0} = 2'b11;
    tick(8);
    {bt1, bt0} = 2'b00;
    tick(6);
    wait_idle("idle_multi");
    check("multi_pv", 32'(pv_seen - pv0), 0);
    check("multi_fail", 32'(fail), 1);
    tick(2);

    // zero-length round; start during done ignored
    dq.push_back('{succ: 1'b1, fl: 1'b0, tmo: 1'b0});
    go(0);
    check("z_busy", 32'(busy), 1);
    check("z_done0", 32'(done), 0);
    tick();
    check("z_done", 32'(done), 1);
    check("z_succ", 32'(success), 1);
    check("z_fail", 32'(fail), 0);
    go(1);
    check("z_ignored", 32'(busy), 0);
    check("z_keep_succ", 32'(success), 1);
    tick(2);

    mem[0] = 2'd0;
`ifdef GENIUS_TIMEOUT_EN
    dq.push_back('{succ: 1'b0, fl: 1'b1, tmo: 1'b1});
    go(1);
    wait_idle("idle_tmo");
    check("tmo_fail", 32'(fail), 1);
    check("tmo_flag", 32'(timeout), 1);
`else
    d0 = done_seen;
    go(1);
    tick(1000);
    check("no_done", 32'(done_seen - d0), 0);
    check("still_busy", 32'(busy), 1);
    pq.push_back('{sym: 2'd0, cnt: 5'd1});
    dq.push_back('{succ: 1'b1, fl: 1'b0, tmo: 1'b0});
    press(0);
    wait_idle("idle_late");
    check("late_tmo", 32'(timeout), 0);
`endif
    tick(2);
    check("pq_empty", 32'(pq.size()), 0);
    check("dq_empty", 32'(dq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
